// File: rtl/pool_engine.sv
// pool_engine: per-channel windowed pooling of interleaved signed samples, result one cycle after the last sample.
// Define POOL_AVG_EN to add the mode port and per-channel average pooling alongside max pooling.
module pool_engine #(
  parameter  int DATA_W = 16,
  parameter  int WIN    = 4,
  parameter  int CH     = 4,
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
`ifdef POOL_AVG_EN
  input  logic                     mode,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_data
);
  localparam int               WIN_W  = $clog2(WIN);
  localparam logic [CH_W:0]    CH_LIM = (CH_W + 1)'(CH);
  localparam logic [WIN_W-1:0] LAST   = WIN_W'(WIN - 1);

  logic [WIN_W-1:0]         r_cnt [CH];
  logic signed [DATA_W-1:0] r_max [CH];
  logic                     r_out_valid;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [DATA_W-1:0] r_out_data;

  logic                     w_take;
  logic                     w_hit;
  logic                     w_first;
  logic                     w_last;
  logic signed [DATA_W-1:0] w_max_nxt;
  logic signed [DATA_W-1:0] w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

  // Out-of-range channels are still handshaken so the producer never stalls on them.
  assign w_take    = clk_en && in_valid && in_ready;
  assign w_hit     = w_take && ({1'b0, in_ch} < CH_LIM);
  assign w_first   = (r_cnt[in_ch] == '0);
  assign w_last    = (r_cnt[in_ch] == LAST);
  assign w_max_nxt = (w_first || (in_data > r_max[in_ch])) ? in_data : r_max[in_ch];

`ifdef POOL_AVG_EN
  localparam int SUM_W = DATA_W + WIN_W;

  logic signed [SUM_W-1:0] r_sum  [CH];
  logic                    r_mode [CH];
  logic signed [SUM_W-1:0] w_ext;
  logic signed [SUM_W-1:0] w_sum_nxt;
  logic                    w_mode;

  assign w_ext     = {{WIN_W{in_data[DATA_W-1]}}, in_data};
  assign w_sum_nxt = w_first ? w_ext : (r_sum[in_ch] + w_ext);
  // Mode is latched with the first sample so a window is pooled one way throughout.
  assign w_mode    = w_first ? mode : r_mode[in_ch];
  assign w_result  = w_mode ? DATA_W'(w_sum_nxt >>> WIN_W) : w_max_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_sum[i]  <= '0;
        r_mode[i] <= 1'b0;
      end
    end else if (w_hit) begin
      r_sum[in_ch]  <= w_sum_nxt;
      r_mode[in_ch] <= w_mode;
    end
  end
`else
  assign w_result = w_max_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
        r_max[i] <= '0;
      end
    end else if (w_hit) begin
      r_cnt[in_ch] <= w_last ? '0 : (r_cnt[in_ch] + WIN_W'(1));
      r_max[in_ch] <= w_max_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else if (clk_en) begin
      if (w_hit && w_last) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= in_ch;
        r_out_data  <= w_result;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width.
REQ-002 SHALL have parameter WIN, default 4: samples per pooling window; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CH, default 4: number of interleaved channels, 1 to 16; CH_W = max(1, clog2(CH)).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port clk_en, input, 1 bit: global clock enable; when low, all state SHALL hold.
REQ-007 SHALL have port in_valid, input, 1 bit: a sample is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample.
REQ-009 SHALL have port in_ch, input, CH_W bits: channel of the sample.
REQ-010 SHALL have port in_data, input, DATA_W bits, signed: the sample.
REQ-011 SHALL have port out_valid, output, 1 bit: a pooled result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_ch, output, CH_W bits: channel of the result.
REQ-014 SHALL have port out_data, output, DATA_W bits, signed: the pooled result.

Function
REQ-015 SHALL accept a sample only when clk_en=1, in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL keep, for each channel, a window counter (0..WIN-1) and an accumulator that are independent of every other channel.
REQ-018 In max mode, the first accepted sample of a window SHALL load the accumulator; each later sample SHALL replace it when it is strictly greater by signed compare.
REQ-019 On acceptance of the WIN-th sample of a channel's window, at the next edge the block SHALL:
- load out_data with the final result, including that sample;
- load out_ch with in_ch;
- set out_valid=1;
- reset that channel's counter to 0.
This gives a latency of one cycle.
REQ-020 out_valid SHALL clear on an edge with clk_en=1 and out_ready=1, unless a new result loads on the same edge, in which case out_valid SHALL stay 1 and the new data SHALL be presented.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_ch SHALL remain stable.
REQ-022 A sample with in_ch >= CH SHALL be accepted and discarded, with no state change.
REQ-023 Counter wrap-around from WIN-1 to 0 SHALL start a fresh window; no stale value SHALL carry into it.
REQ-024 Only one sample is accepted per cycle; therefore at most one result is produced per cycle.

Reset
REQ-025 While reset=1, the block SHALL asynchronously clear:
- out_valid=0, out_data=0, out_ch=0;
- all counters and accumulators to 0.
REQ-026 Reset asserted mid-window SHALL discard all partial windows; the first sample after release SHALL be counted as sample 1 of its channel.

Configuration
REQ-027 Macro POOL_AVG_EN:
- When defined, the block SHALL add input port mode, 1 bit (0=max, 1=average).
- In average mode, each channel SHALL sum its window in DATA_W+clog2(WIN) bits.
- The average-mode result SHALL be the sum arithmetic-shifted right by clog2(WIN) (floor), truncated to DATA_W.
- mode SHALL be sampled only at the first sample of each window; a change of mode mid-window SHALL not affect that window.
- When not defined, the block SHALL have no mode port, no sum logic, and max mode only.

Verification
REQ-028 Scenario: CH=1, WIN=4; feed -5,-9,-2,-7 -> out_data=-2, out_valid=1 exactly one cycle after the 4th accept.
REQ-029 Scenario: CH=2; interleave ch0: 1,8,3,4 and ch1: 10,2,2,2 -> results ch1=10 and ch0=8, with matching out_ch and no cross-contamination.
REQ-030 Scenario: hold out_ready=0 while a result is pending -> in_ready=0, out_data stable, no samples lost; then raise out_ready together with a completing sample -> back-to-back results with out_valid held at 1.
REQ-031 Scenario: assert reset after 2 of 4 samples of ch0 -> outputs become 0; the next 4 samples 3,1,1,1 give 3.
REQ-032 Scenario: clk_en=0 for 3 cycles mid-window with in_valid=1 -> no accepts and no state change; the result is identical to an unpaused run.
REQ-033 Scenario (POOL_AVG_EN defined): mode=1, samples 7,8,-3,0 -> sum 12, out_data=3; samples -1,0,0,0 -> out_data=-1.
